// File: rtl/task_sequencer_if.sv
// Control/status bundle between the top-level controller and the task sequencer.
interface task_sequencer_if #(
    parameter int unsigned NUM_TASKS = 4,
    parameter int unsigned IDX_W     = 2,
    parameter int unsigned TIMEOUT_W = 16
);
    logic                 enable;
    logic [NUM_TASKS-1:0] task_mask;
    logic [NUM_TASKS-1:0] done;
    logic [TIMEOUT_W-1:0] timeout_limit;
    logic                 clr_flags;
    logic [NUM_TASKS-1:0] grant;
    logic [IDX_W-1:0]     active_idx;
    logic                 busy;
    logic                 timeout_pulse;
    logic [NUM_TASKS-1:0] timeout_flags;
    logic                 led;

    modport master (
        output enable, task_mask, done, timeout_limit, clr_flags,
        input  grant, active_idx, busy, timeout_pulse, timeout_flags, led
    );

    modport slave (
        input  enable, task_mask, done, timeout_limit, clr_flags,
        output grant, active_idx, busy, timeout_pulse, timeout_flags, led
    );
endinterface

// File: rtl/task_sequencer.sv
// Round-robin task sequencer: grants one task engine at a time, advances on done,
// skips masked tasks and forcibly releases a grant after an optional watchdog limit.
module task_sequencer #(
    parameter int unsigned NUM_TASKS = 4,
    parameter int unsigned IDX_W     = 2,
    parameter int unsigned TIMEOUT_W = 16
) (
    input logic             clk,
    input logic             rst,
    task_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        GRANT  = 2'd2
    } state_t;

    state_t               state_q;
    logic [NUM_TASKS-1:0] grant_q;
    logic [IDX_W-1:0]     active_idx_q;
    logic [IDX_W-1:0]     ptr_q;
    logic                 busy_q;
    logic                 timeout_pulse_q;
    logic [NUM_TASKS-1:0] timeout_flags_q;
    logic [TIMEOUT_W-1:0] wd_cnt_q;
    logic [TIMEOUT_W-1:0] limit_q;

    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [NUM_TASKS-1:0] sel_onehot;
    logic                 cand_bit;
    int unsigned          cand;
    logic                 done_hit;
    logic                 wd_expired;

    // Cyclic search from ptr+1; ptr itself is visited last.
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        cand       = 0;
        cand_bit   = 1'b0;
        sel_onehot = '0;
        for (int unsigned i = 1; i <= NUM_TASKS; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NUM_TASKS) begin
                cand = cand - NUM_TASKS;
            end
            cand_bit = 1'b0;
            for (int unsigned k = 0; k < NUM_TASKS; k++) begin
                if (k == cand) begin
                    cand_bit = bus.task_mask[k];
                end
            end
            if (!sel_found && cand_bit) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
        for (int unsigned k = 0; k < NUM_TASKS; k++) begin
            sel_onehot[k] = (sel_idx == IDX_W'(k));
        end
    end

    // grant_q is one-hot at active_idx during GRANT, so it doubles as the done selector.
    assign done_hit   = |(bus.done & grant_q);
    assign wd_expired = (limit_q != '0) && (wd_cnt_q == limit_q - TIMEOUT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            grant_q         <= '0;
            active_idx_q    <= '0;
            ptr_q           <= IDX_W'(NUM_TASKS - 1);
            busy_q          <= 1'b0;
            timeout_pulse_q <= 1'b0;
            timeout_flags_q <= '0;
            wd_cnt_q        <= '0;
            limit_q         <= '0;
        end else begin
            timeout_pulse_q <= 1'b0;
            if (bus.clr_flags) begin
                timeout_flags_q <= '0;
            end
            case (state_q)
                IDLE: begin
                    grant_q <= '0;
                    if (bus.enable && (|bus.task_mask)) begin
                        state_q <= SELECT;
                        busy_q  <= 1'b1;
                    end
                end
                SELECT: begin
                    if (!bus.enable || !sel_found) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q      <= GRANT;
                        active_idx_q <= sel_idx;
                        ptr_q        <= sel_idx;
                        grant_q      <= sel_onehot;
                        limit_q      <= bus.timeout_limit;
                        wd_cnt_q     <= '0;
                    end
                end
                GRANT: begin
                    wd_cnt_q <= wd_cnt_q + TIMEOUT_W'(1);
                    if (done_hit) begin
                        state_q <= SELECT;
                        grant_q <= '0;
                    end else if (wd_expired) begin
                        state_q         <= SELECT;
                        grant_q         <= '0;
                        timeout_pulse_q <= 1'b1;
                        // A flag being set survives a coincident clear.
                        timeout_flags_q <= (bus.clr_flags ? '0 : timeout_flags_q) | grant_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant         = grant_q;
    assign bus.active_idx    = active_idx_q;
    assign bus.busy          = busy_q;
    assign bus.led           = busy_q;
    assign bus.timeout_pulse = timeout_pulse_q;
    assign bus.timeout_flags = timeout_flags_q;

endmodule

// File: tb/tb_task_sequencer.sv
// Directed self-checking bench for task_sequencer with hand-computed expected values.
module tb_task_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    task_sequencer_if #(.NUM_TASKS(4), .IDX_W(2), .TIMEOUT_W(16)) bus ();

    task_sequencer #(.NUM_TASKS(4), .IDX_W(2), .TIMEOUT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered in grant cycle 1; holds done off for len-1 cycles, raises it on cycle len, ends in the gap cycle.
    task automatic serve(input logic [3:0] exp, input int len);
        check("grant", 32'(bus.grant), 32'(exp));
        for (int c = 1; c < len; c++) begin
            tick();
            check("grant_hold", 32'(bus.grant), 32'(exp));
        end
        bus.done = exp;
        tick();
        bus.done = 4'b0000;
        check("grant_gap", 32'(bus.grant), 32'h0);
    endtask

    // Entered in grant cycle 1; task never reports done, ends in the SELECT cycle carrying the pulse.
    task automatic expire(input logic [3:0] exp, input int len, input logic clr_last);
        check("wd_grant", 32'(bus.grant), 32'(exp));
        for (int c = 1; c < len; c++) begin
            tick();
            check("wd_grant_hold", 32'(bus.grant), 32'(exp));
            check("wd_no_pulse", 32'(bus.timeout_pulse), 32'h0);
        end
        bus.clr_flags = clr_last;
        tick();
        bus.clr_flags = 1'b0;
        check("wd_release", 32'(bus.grant), 32'h0);
        check("wd_pulse", 32'(bus.timeout_pulse), 32'h1);
    endtask

    initial begin
        rst               = 1'b0;
        bus.enable        = 1'b0;
        bus.task_mask     = 4'b0000;
        bus.done          = 4'b0000;
        bus.timeout_limit = 16'd0;
        bus.clr_flags     = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_led", 32'(bus.led), 32'h0);
        check("rst_idx", 32'(bus.active_idx), 32'h0);
        check("rst_pulse", 32'(bus.timeout_pulse), 32'h0);
        check("rst_flags", 32'(bus.timeout_flags), 32'h0);

        // Full rotation, done after 3 grant cycles
        rst           = 1'b0;
        bus.enable    = 1'b1;
        bus.task_mask = 4'b1111;
        tick();
        check("select_grant", 32'(bus.grant), 32'h0);
        check("select_busy", 32'(bus.busy), 32'h1);
        tick();
        check("first_idx", 32'(bus.active_idx), 32'h0);
        serve(4'b0001, 3); tick();
        check("idx1", 32'(bus.active_idx), 32'h1);
        serve(4'b0010, 3); tick();
        serve(4'b0100, 3); tick();
        check("idx3", 32'(bus.active_idx), 32'h3);
        serve(4'b1000, 3); tick();
        check("wrap_idx", 32'(bus.active_idx), 32'h0);

        // Sparse mask, then mask change mid-grant of task 3
        bus.task_mask = 4'b1010;
        serve(4'b0001, 2); tick();
        serve(4'b0010, 2); tick();
        serve(4'b1000, 2); tick();
        serve(4'b0010, 2); tick();
        bus.task_mask = 4'b0001;
        serve(4'b1000, 2); tick();
        serve(4'b0001, 2); tick();
        serve(4'b0001, 1);

        // Watchdog: task 2 never reports done
        bus.task_mask     = 4'b1111;
        bus.timeout_limit = 16'd5;
        tick();
        serve(4'b0010, 2); tick();
        expire(4'b0100, 5, 1'b0);
        check("wd_flags", 32'(bus.timeout_flags), 32'h4);
        tick();
        check("wd_next_grant", 32'(bus.grant), 32'h8);
        check("pulse_one_cycle", 32'(bus.timeout_pulse), 32'h0);
        bus.clr_flags = 1'b1;
        tick();
        bus.clr_flags = 1'b0;
        check("clr_flags", 32'(bus.timeout_flags), 32'h0);
        check("grant_after_clr", 32'(bus.grant), 32'h8);
        bus.done = 4'b1000;
        tick();
        bus.done = 4'b0000;
        check("done_release", 32'(bus.grant), 32'h0);
        tick();

        // done coincident with expiry: done wins
        serve(4'b0001, 5);
        check("tie_no_pulse", 32'(bus.timeout_pulse), 32'h0);
        check("tie_no_flag", 32'(bus.timeout_flags), 32'h0);
        tick();

        // Two expiries; clear coincides with second flag set
        expire(4'b0010, 5, 1'b0);
        check("flag_task1", 32'(bus.timeout_flags), 32'h2);
        tick();
        expire(4'b0100, 5, 1'b1);
        check("set_beats_clr", 32'(bus.timeout_flags), 32'h4);

        // enable drop during grant of task 1
        bus.timeout_limit = 16'd0;
        tick();
        serve(4'b1000, 2); tick();
        serve(4'b0001, 2); tick();
        bus.enable = 1'b0;
        serve(4'b0010, 3);
        check("drop_select_busy", 32'(bus.busy), 32'h1);
        tick();
        check("drop_idle_busy", 32'(bus.busy), 32'h0);
        check("drop_idle_led", 32'(bus.led), 32'h0);
        check("drop_idle_grant", 32'(bus.grant), 32'h0);
        tick();
        check("stay_idle", 32'(bus.busy), 32'h0);
        bus.enable = 1'b1;
        tick();
        check("reen_select", 32'(bus.busy), 32'h1);
        check("reen_gap", 32'(bus.grant), 32'h0);
        tick();
        check("reen_grant", 32'(bus.grant), 32'h4);
        check("reen_idx", 32'(bus.active_idx), 32'h2);

        // Asynchronous reset mid-grant
        #2 rst = 1'b1;
        #1;
        check("arst_grant", 32'(bus.grant), 32'h0);
        check("arst_busy", 32'(bus.busy), 32'h0);
        check("arst_led", 32'(bus.led), 32'h0);
        check("arst_flags", 32'(bus.timeout_flags), 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_select", 32'(bus.busy), 32'h1);
        tick();
        check("post_rst_grant", 32'(bus.grant), 32'h1);
        check("post_rst_idx", 32'(bus.active_idx), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/task_sequencer.md
# task_sequencer

Parametrised round-robin task sequencer for the logic analyser. It grants exclusive run permission to one of NUM_TASKS sub-blocks at a time (acquisition, transmit, trigger arm, etc.) and advances when the granted task signals done. Tasks can be skipped at run time with a mask. An optional per-grant watchdog forcibly releases a task that never reports done. It sits between the top-level control and the task engines, and drives the status LED.

## Interface
Parameters:
- NUM_TASKS, 4: number of task channels; valid range 1..16.
- IDX_W, 2: index width; must satisfy 2^IDX_W >= NUM_TASKS.
- TIMEOUT_W, 16: watchdog counter and limit width.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  1 = sequencer runs; 0 = stop after the current grant completes.
- task_mask  in  NUM_TASKS  1 = task participates in rotation.
- done  in  NUM_TASKS  level, per task; only the bit of the granted task is sampled.
- timeout_limit  in  TIMEOUT_W  maximum grant length in cycles; 0 disables the watchdog.
- clr_flags  in  1  single-cycle pulse that clears timeout_flags.
- grant  out  NUM_TASKS  one-hot or zero; registered.
- active_idx  out  IDX_W  index of the last selected task; registered.
- busy  out  1  1 whenever the state is not IDLE.
- timeout_pulse  out  1  one-cycle pulse when a watchdog release occurs.
- timeout_flags  out  NUM_TASKS  sticky per-task timeout record.
- led  out  1  equals busy.

## Operation
- Reset values:
  - state = IDLE; grant = 0; active_idx = 0; busy = 0; led = 0.
  - timeout_pulse = 0; timeout_flags = 0.
  - Internal pointer ptr = NUM_TASKS-1, so the first search starts at task 0.
  - Watchdog count = 0; latched limit = 0.
- States: IDLE, SELECT, GRANT.
- IDLE:
  - grant = 0.
  - Go to SELECT when enable = 1 and |task_mask = 1; otherwise stay.
- SELECT (one cycle, grant = 0):
  - If enable = 0 or task_mask = 0, go to IDLE.
  - Otherwise search cyclically from ptr+1, wrapping at NUM_TASKS-1 to 0. Pick the first task with its mask bit set; ptr itself is checked last.
  - Register the result into active_idx and ptr.
  - Latch timeout_limit, clear the watchdog count, go to GRANT.
- GRANT:
  - grant[active_idx] = 1; all other grant bits are 0.
  - Watchdog count increments every cycle in GRANT.
  - If done[active_idx] = 1, go to SELECT.
  - Else if latched limit != 0 and count = limit-1, go to SELECT, set timeout_flags[active_idx], and assert timeout_pulse for one cycle.
- Priority and boundary rules:
  - done and watchdog expiry in the same cycle: done wins; no flag, no pulse.
  - done bits of non-granted tasks are ignored in every state.
  - enable falling during GRANT: no preemption; the task runs to done or timeout, then SELECT leads to IDLE.
  - task_mask or timeout_limit changes during GRANT do not affect the current grant; they take effect at the next SELECT.
  - Clearing the currently granted task's mask bit does not revoke its grant.
  - NUM_TASKS = 1, or only one mask bit set: the same task is re-granted after each one-cycle gap.
  - clr_flags and a flag set on the same cycle: the set wins for that bit; other bits clear.
  - Reset mid-grant: grant drops asynchronously; rotation restarts at task 0.

## Timing
- enable rising, sampled at edge E, with state IDLE: SELECT at E, grant asserted from edge E+1.
- done[active_idx] sampled high at edge D: grant low from edge D (SELECT). The next task's grant goes high at D+1.
- There is always exactly one grant-low cycle between consecutive grants.
- Watchdog with limit L: grant stays high for exactly L cycles. timeout_pulse is high in the cycle after the last grant cycle, coincident with SELECT.
- done is level-sampled. A task must drop done before its next grant, or that grant will last one cycle.
- grant, active_idx, busy, timeout_pulse and timeout_flags are all registered; no combinational input-to-output paths.

## Test plan
- Reset, then enable=1, mask=4'b1111, limit=0, done pulsed 3 cycles after each grant: grant sequence 0001, 0010, 0100, 1000, 0001, with one zero cycle between grants.
- mask=4'b1010: grants alternate 0010 and 1000. Change mask to 4'b0001 mid-grant of task 3: task 3 completes, next grant is 0001.
- limit=5, task 2 never asserts done: grant[2] high for exactly 5 cycles, then timeout_pulse for 1 cycle and timeout_flags = 4'b0100. Rotation continues to task 3. clr_flags clears the flags.
- limit=5, done[active_idx] asserted on the 5th grant cycle: normal release, timeout_pulse = 0, flags unchanged.
- Drop enable during the grant of task 1: grant[1] holds until done, then one SELECT cycle, then IDLE with busy=0 and led=0. Re-enabling grants task 2.
- Assert rst mid-grant: grant = 0 and busy = 0 immediately. After release with enable=1, the first grant is 0001.
